// File: rtl/systolic_mm_sequencer.sv
// -----------------------------------------------------------------------------
// systolic_mm_sequencer
//
// Purpose
//   Sequences one matrix multiply C = A*B on an NxN systolic array. B is pushed
//   into the array with a single weight-load strobe. A rows are then streamed
//   from a valid/ready host port, and each row's C result is returned on a
//   valid/ready consumer port. The array's own arithmetic is not modelled
//   here: a one-bit tag follows every A row through the array latency so the
//   block knows when arr_c_out carries a real result. Consumer backpressure
//   freezes the array, the tags and the A port together.
//
// Optional feature
//   SA_SEQ_PERF_CNT_EN : when defined, adds the saturating 32-bit counters
//                        perf_busy_cycles and perf_stall_cycles.
//
// Ports
//   clk          clock, all logic on posedge
//   rst_n        synchronous reset, active-low
//   start        begin job (only honoured in IDLE)
//   num_rows     A rows in the job, latched at start
//   b_mat_in     B matrix, element (k,j) at index k*N+j, latched at start
//   busy         high in every state except IDLE
//   done         one-cycle pulse at job end
//   a_valid      host offers an A row
//   a_ready      A row accepted when a_valid && a_ready
//   a_row        A row, element k at index k
//   c_valid      C row available
//   c_ready      consumer takes the C row
//   c_row        C row (straight from arr_c_out)
//   c_last       c_valid on the final row of the job
//   arr_enable   array advance
//   arr_b_load   array weight-load strobe
//   arr_b_in     B to the array
//   arr_a_in     A row to the array, zero on bubbles
//   arr_c_out    array result row
//   perf_busy_cycles   (SA_SEQ_PERF_CNT_EN) cycles spent in LOAD_B..DONE
//   perf_stall_cycles  (SA_SEQ_PERF_CNT_EN) cycles with output stalled
// -----------------------------------------------------------------------------
module systolic_mm_sequencer #(
  parameter int N          = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int MAX_ROWS   = 256,
  parameter int ARRAY_LAT  = 3,
  parameter int ROW_W      = $clog2(MAX_ROWS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ROW_W-1:0]              num_rows,
  input  logic [N*N*DATA_WIDTH-1:0]     b_mat_in,
  output logic                          busy,
  output logic                          done,
  input  logic                          a_valid,
  output logic                          a_ready,
  input  logic [N*DATA_WIDTH-1:0]       a_row,
  output logic                          c_valid,
  input  logic                          c_ready,
  output logic [N*ACC_WIDTH-1:0]        c_row,
  output logic                          c_last,
  output logic                          arr_enable,
  output logic                          arr_b_load,
  output logic [N*N*DATA_WIDTH-1:0]     arr_b_in,
  output logic [N*DATA_WIDTH-1:0]       arr_a_in,
  input  logic [N*ACC_WIDTH-1:0]        arr_c_out
`ifdef SA_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_busy_cycles,
  output logic [31:0]                   perf_stall_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_B = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t                       state_q;
  logic [ROW_W-1:0]             num_rows_q;
  logic [ROW_W-1:0]             rows_in_q;
  logic [ROW_W-1:0]             rows_out_q;
  logic [N*N*DATA_WIDTH-1:0]    b_q;
  logic                         busy_q;
  logic                         done_q;
  logic                         b_load_q;

  // Tag pipe: tag_q[i] is set when the array stage i holds a real A row.
  logic [ARRAY_LAT-1:0]         tag_q;
  logic [ARRAY_LAT-1:0]         tag_d;

  logic                         active;
  logic                         stall;
  logic                         a_accept;
  logic                         c_fire;
  logic                         last_in;
  logic                         last_out;

  // ---------------------------------------------------------------------------
  // Handshake decode. These must be combinational: a consumer dropping c_ready
  // has to freeze the array in the very same cycle, otherwise the result on
  // arr_c_out would be overwritten before it is taken.
  // ---------------------------------------------------------------------------
  assign active     = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign c_valid    = active && tag_q[ARRAY_LAT-1];
  assign stall      = c_valid && !c_ready;
  assign arr_enable = active && !stall;
  assign a_ready    = (state_q == S_STREAM) && !stall;
  assign a_accept   = a_valid && a_ready;
  assign c_fire     = c_valid && c_ready;

  // Bubbles feed zeros so the array never accumulates stale host data.
  assign arr_a_in   = a_accept ? a_row : '0;

  assign last_in    = (rows_in_q  == (num_rows_q - ROW_W'(1)));
  assign last_out   = (rows_out_q == (num_rows_q - ROW_W'(1)));
  assign c_last     = c_valid && last_out;

  assign c_row      = arr_c_out;
  assign arr_b_in   = b_q;

  assign busy       = busy_q;
  assign done       = done_q;
  assign arr_b_load = b_load_q;

  // ---------------------------------------------------------------------------
  // Tag pipe next state: stage 0 captures the accept, later stages shift.
  // ---------------------------------------------------------------------------
  assign tag_d[0] = a_accept;

  genvar gi;
  generate
    for (gi = 1; gi < ARRAY_LAT; gi++) begin : g_tag
      assign tag_d[gi] = tag_q[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q <= '0;
    end else if (state_q == S_LOAD_B) begin
      // Any leftovers from an earlier job must never surface as c_valid.
      tag_q <= '0;
    end else if (arr_enable) begin
      tag_q <= tag_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Job FSM with registered busy/done/b_load outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      num_rows_q <= '0;
      rows_in_q  <= '0;
      rows_out_q <= '0;
      b_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      b_load_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      b_load_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            num_rows_q <= num_rows;
            b_q        <= b_mat_in;
            rows_in_q  <= '0;
            rows_out_q <= '0;
            busy_q     <= 1'b1;
            b_load_q   <= 1'b1;
            state_q    <= S_LOAD_B;
          end
        end

        S_LOAD_B: begin
          if (num_rows_q == '0) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q <= S_STREAM;
          end
        end

        S_STREAM: begin
          // An A accept and a C handshake may share a cycle; both count.
          if (a_accept) begin
            rows_in_q <= rows_in_q + ROW_W'(1);
            if (last_in) begin
              state_q <= S_DRAIN;
            end
          end
          if (c_fire) begin
            rows_out_q <= rows_out_q + ROW_W'(1);
          end
        end

        S_DRAIN: begin
          if (c_fire) begin
            rows_out_q <= rows_out_q + ROW_W'(1);
            if (last_out) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SA_SEQ_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters, cleared when a job is accepted.
  // ---------------------------------------------------------------------------
  logic [31:0] perf_busy_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy_q && (perf_busy_q != 32'hFFFF_FFFF)) begin
        perf_busy_q <= perf_busy_q + 32'd1;
      end
      if (stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_busy_cycles  = perf_busy_q;
  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_systolic_mm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_systolic_mm_sequencer
//
// Directed bench for systolic_mm_sequencer. A small behavioural array model
// (weight register plus ARRAY_LAT-deep enabled pipeline) closes the loop on
// the arr_* ports. Jobs push their hand-computed C rows into a scoreboard
// queue; an independent monitor pops and compares on every C handshake.
// -----------------------------------------------------------------------------
module tb_systolic_mm_sequencer;

  localparam int N    = 2;
  localparam int DW   = 8;
  localparam int AW   = 32;
  localparam int MAXR = 256;
  localparam int LAT  = 3;
  localparam int RW   = $clog2(MAXR + 1);

  logic                 clk      = 1'b0;
  logic                 rst_n    = 1'b0;
  logic                 start    = 1'b0;
  logic [RW-1:0]        num_rows = '0;
  logic [N*N*DW-1:0]    b_mat_in = '0;
  logic                 busy;
  logic                 done;
  logic                 a_valid  = 1'b0;
  logic                 a_ready;
  logic [N*DW-1:0]      a_row    = '0;
  logic                 c_valid;
  logic                 c_ready  = 1'b1;
  logic [N*AW-1:0]      c_row;
  logic                 c_last;
  logic                 arr_enable;
  logic                 arr_b_load;
  logic [N*N*DW-1:0]    arr_b_in;
  logic [N*DW-1:0]      arr_a_in;
  logic [N*AW-1:0]      arr_c_out;
`ifdef SA_SEQ_PERF_CNT_EN
  logic [31:0]          perf_busy_cycles;
  logic [31:0]          perf_stall_cycles;
`endif

  always #5 clk = ~clk;

  systolic_mm_sequencer #(
    .N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .MAX_ROWS(MAXR), .ARRAY_LAT(LAT), .ROW_W(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows), .b_mat_in(b_mat_in),
    .busy(busy), .done(done), .a_valid(a_valid), .a_ready(a_ready), .a_row(a_row),
    .c_valid(c_valid), .c_ready(c_ready), .c_row(c_row), .c_last(c_last),
    .arr_enable(arr_enable), .arr_b_load(arr_b_load), .arr_b_in(arr_b_in),
    .arr_a_in(arr_a_in), .arr_c_out(arr_c_out)
`ifdef SA_SEQ_PERF_CNT_EN
    , .perf_busy_cycles(perf_busy_cycles), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  // ---------------------------------------------------------------------------
  // Behavioural array: C row = A row * B, ARRAY_LAT enabled cycles later.
  // ---------------------------------------------------------------------------
  logic signed [DW-1:0] bm [N][N] = '{default: '0};
  logic [N*AW-1:0]      pipe [LAT] = '{default: '0};

  function automatic logic [N*AW-1:0] mm(input logic [N*DW-1:0] a);
    logic [N*AW-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++) begin
      int s;
      s = 0;
      for (int k = 0; k < N; k++) begin
        s += int'($signed(a[k*DW +: DW])) * int'(bm[k][j]);
      end
      r[j*AW +: AW] = AW'(s);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (arr_b_load) begin
      for (int k = 0; k < N; k++)
        for (int j = 0; j < N; j++)
          bm[k][j] <= arr_b_in[(k*N+j)*DW +: DW];
    end
    if (arr_enable) begin
      pipe[0] <= mm(arr_a_in);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign arr_c_out = pipe[LAT-1];

  // ---------------------------------------------------------------------------
  // Scoreboard state and helpers
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [N*AW-1:0] row;
    logic            last;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              mon_e;
  logic [N*DW-1:0]   rows_q[$];
  int                gaps[$];
  int                hs_q[$];
  int                vectors     = 0;
  int                miscompares = 0;
  int                cyc         = 0;
  int                done_cnt    = 0;
  int                done_cyc    = 0;
  int                bload_cnt   = 0;
  int                cvalid_cnt  = 0;
  int                hs_total    = 0;
  int                last_start_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [N*DW-1:0] arow(input int a0, input int a1);
    return {DW'(a1), DW'(a0)};
  endfunction

  function automatic logic [N*N*DW-1:0] bpack(input int b00, input int b01, input int b10, input int b11);
    return {DW'(b11), DW'(b10), DW'(b01), DW'(b00)};
  endfunction

  function automatic logic [N*AW-1:0] crow(input int c0, input int c1);
    return {AW'(c1), AW'(c0)};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Monitor: pops the scoreboard on every C handshake.
  // ---------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (arr_b_load) bload_cnt++;
        if (c_valid) cvalid_cnt++;
        if (c_valid && c_ready) begin
          hs_q.push_back(cyc);
          hs_total++;
          $display("c_row #%0d = 0x%h last=%0b (cycle %0d)", hs_total, c_row, c_last, cyc);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_c_row: got 0x%0h, expected no row", c_row);
          end else begin
            mon_e = exp_q.pop_front();
            chk("c_row", c_row, mon_e.row);
            chk("c_last", c_last, mon_e.last);
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Job driver: start, feed `feed` rows (with optional per-row gaps), wait done.
  // ---------------------------------------------------------------------------
  task automatic run_job(input int n, input logic [N*N*DW-1:0] b, input int feed, input bit wait_done);
    int  sc;
    bit  acc;
    bit  seen;
    hs_q.delete();
    @(posedge clk); #1;
    start    = 1'b1;
    num_rows = RW'(n);
    b_mat_in = b;
    sc       = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int idx = 0; idx < feed; idx++) begin
      for (int g = 0; g < ((idx < gaps.size()) ? gaps[idx] : 0); g++) begin
        a_valid = 1'b0;
        a_row   = {N{8'h5A}};
        @(negedge clk); #2;
        if (a_ready) chk("bubble_arr_a_in", arr_a_in, '0);
        @(posedge clk); #1;
      end
      a_valid = 1'b1;
      a_row   = rows_q[idx];
      acc     = 1'b0;
      for (int t = 0; t < 300 && !acc; t++) begin
        @(negedge clk); #2;
        acc = a_ready;
        @(posedge clk); #1;
      end
      if (!acc) begin
        fail_now("a_accept_timeout");
        break;
      end
    end
    a_valid = 1'b0;
    a_row   = '0;
    if (wait_done) begin
      seen = 1'b0;
      for (int t = 0; t < 2000 && !seen; t++) begin
        @(negedge clk); #2;
        seen = done;
      end
      #1;
      if (!seen) fail_now("done_timeout");
      last_start_cyc = sc;
    end
  endtask

  task automatic check_idle(input string pfx);
    chk({pfx, "_busy"},       busy,       '0);
    chk({pfx, "_done"},       done,       '0);
    chk({pfx, "_a_ready"},    a_ready,    '0);
    chk({pfx, "_c_valid"},    c_valid,    '0);
    chk({pfx, "_c_last"},     c_last,     '0);
    chk({pfx, "_arr_enable"}, arr_enable, '0);
    chk({pfx, "_arr_b_load"}, arr_b_load, '0);
    chk({pfx, "_arr_a_in"},   arr_a_in,   '0);
  endtask

  task automatic push_basic();
    exp_q.push_back('{row: crow(19, 22), last: 1'b0});
    exp_q.push_back('{row: crow(43, 50), last: 1'b1});
  endtask

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  logic [N*N*DW-1:0] b1;
  int b0, d0, c0;

  initial begin
    b1 = bpack(5, 6, 7, 8);

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    check_idle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Test 1: basic 2-row job, no stalls
    rows_q.delete();
    rows_q.push_back(arow(1, 2));
    rows_q.push_back(arow(3, 4));
    b0 = bload_cnt;
    d0 = done_cnt;
    push_basic();
    run_job(2, b1, 2, 1'b1);
    chk("t1_b_load_cycles", bload_cnt - b0, 1);
    chk("t1_done_count", done_cnt - d0, 1);
    chk("t1_hs_count", hs_q.size(), 2);
    if (hs_q.size() == 2) begin
      chk("t1_rows_back_to_back", hs_q[1] - hs_q[0], 1);
      chk("t1_done_after_last", done_cyc - hs_q[1], 1);
    end
    chk("t1_scoreboard_empty", exp_q.size(), 0);
`ifdef SA_SEQ_PERF_CNT_EN
    chk("t1_perf_busy", perf_busy_cycles, 7);
`endif
    @(negedge clk); #2;
    chk("t1_done_one_cycle", done, 0);

    // Test 2: consumer holds off for 4 cycles on the first C row
    push_basic();
    fork
      run_job(2, b1, 2, 1'b1);
      begin
        bit got;
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
          @(negedge clk);
          got = c_valid;
        end
        if (!got) fail_now("t2_first_c_valid");
        c_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
          #2;
          chk("t2_hold_c_valid", c_valid, 1);
          chk("t2_hold_c_row", c_row, crow(19, 22));
          chk("t2_hold_arr_enable", arr_enable, 0);
          @(posedge clk);
          @(negedge clk);
        end
        c_ready = 1'b1;
      end
    join
    chk("t2_scoreboard_empty", exp_q.size(), 0);
`ifdef SA_SEQ_PERF_CNT_EN
    chk("t2_perf_stall", perf_stall_cycles, 4);
`endif

    // Test 3: a_valid pattern 1,0,0,1 -> two bubbles
    gaps.delete();
    gaps.push_back(0);
    gaps.push_back(2);
    push_basic();
    run_job(2, b1, 2, 1'b1);
    gaps.delete();
    chk("t3_hs_count", hs_q.size(), 2);
    if (hs_q.size() == 2) chk("t3_c_valid_gap", hs_q[1] - hs_q[0], 3);
    chk("t3_scoreboard_empty", exp_q.size(), 0);

    // Test 4: empty job
    b0 = bload_cnt;
    c0 = cvalid_cnt;
    run_job(0, b1, 0, 1'b1);
    chk("t4_done_latency", done_cyc - last_start_cyc, 2);
    chk("t4_b_load_cycles", bload_cnt - b0, 1);
    chk("t4_no_c_valid", cvalid_cnt - c0, 0);

    // Test 5: reset in STREAM after one accepted row
    d0 = done_cnt;
    run_job(2, b1, 1, 1'b0);
    a_valid = 1'b1;
    a_row   = arow(9, 9);
    rst_n   = 1'b0;
    @(posedge clk);
    @(negedge clk); #2;
    check_idle("t5_abort");
    @(posedge clk); #1;
    rst_n   = 1'b1;
    a_valid = 1'b0;
    a_row   = '0;
    chk("t5_no_done_on_abort", done_cnt - d0, 0);
    push_basic();
    run_job(2, b1, 2, 1'b1);
    chk("t5_fresh_done_count", done_cnt - d0, 1);
    chk("t5_scoreboard_empty", exp_q.size(), 0);

    // Test 6: MAX_ROWS rows through identity B, with a stray start mid-job
    rows_q.delete();
    for (int i = 0; i < MAXR; i++) begin
      logic [DW-1:0] x0, x1;
      x0 = DW'(i);
      x1 = DW'(i * 7 + 3);
      rows_q.push_back({x1, x0});
      exp_q.push_back('{row: crow(int'($signed(x0)), int'($signed(x1))), last: (i == MAXR - 1)});
    end
    d0 = done_cnt;
    b0 = bload_cnt;
    fork
      run_job(MAXR, bpack(1, 0, 0, 1), MAXR, 1'b1);
      begin
        repeat (10) @(posedge clk);
        #1;
        start    = 1'b1;
        num_rows = RW'(5);
        @(posedge clk); #1;
        start    = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    #2;
    chk("t6_idle_after_job", busy, 0);
    chk("t6_done_count", done_cnt - d0, 1);
    chk("t6_b_load_cycles", bload_cnt - b0, 1);
    chk("t6_scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
